// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB)
// Optional BNE support (opcode 0x6) is enabled by defining MC_CONTROL_BNE_EN.
module mc_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [3:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        illegal,
  output logic [2:0]  state
);

  localparam logic [3:0] FUNCT_ADD = 4'h0;
  localparam logic [3:0] FUNCT_SUB = 4'h1;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_J     = 4'h5;
`ifdef MC_CONTROL_BNE_EN
  localparam logic [3:0] OP_BNE   = 4'h6;
  localparam logic [3:0] OP_MAX   = 4'h6;
`else
  localparam logic [3:0] OP_MAX   = 4'h5;
`endif

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [3:0] opcode;
  logic [3:0] funct;
  logic       op_legal;
  logic       unused_instr_bits;

  assign opcode            = instr[15:12];
  assign funct             = instr[3:0];
  assign op_legal          = (opcode <= OP_MAX);
  assign unused_instr_bits = ^instr[11:4];

  always_comb begin
    state_d    = state_q;
    alu_op     = FUNCT_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_legal) begin
          state_d = S_EXEC;
        end else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_RTYPE: begin
            alu_src_a = 1'b1;
            alu_op    = funct;
            state_d   = S_WB;
          end
          OP_ADDI: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_d   = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_d   = S_MEM;
          end
          OP_BEQ: begin
            alu_src_a = 1'b1;
            alu_op    = FUNCT_SUB;
            pc_write  = zero;
          end
`ifdef MC_CONTROL_BNE_EN
          OP_BNE: begin
            alu_src_a = 1'b1;
            alu_op    = FUNCT_SUB;
            pc_write  = ~zero;
          end
`endif
          OP_J: pc_write = 1'b1;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        // Only LW/SW reach MEM, so anything that is not LW is treated as a store.
        mem_read  = (opcode == OP_LW);
        mem_write = (opcode != OP_LW);
        if (mem_ready) begin
          state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OP_LW);
        reg_dst    = (opcode == OP_RTYPE);
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
      state_d   = S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: instr  input  16  instruction register contents; opcode = instr[15:12], funct = instr[3:0].
REQ-004 SHALL have port: zero  input  1  ALU zero flag, consumed in EXEC only.
REQ-005 SHALL have port: mem_ready  input  1  memory access complete this cycle.
REQ-006 SHALL have port: alu_op  output  4  ALU operation, encoded with the `FUNCT_*` codes of simple/asm.vh.
REQ-007 SHALL have port: alu_src_a  output  1  0 = PC, 1 = register A.
REQ-008 SHALL have port: alu_src_b  output  2  0 = register B, 1 = constant 2, 2 = sign-extended instr[7:0].
REQ-009 SHALL have outputs, 1 bit each: pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, reg_dst (1 = rd field), illegal.
REQ-010 SHALL have port: state  output  3  current FSM state, for debug.

Function
REQ-011 SHALL implement FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; values 5-7 unreachable and SHALL go to FETCH.
REQ-012 All outputs SHALL be combinational functions of state, instr, zero and mem_ready; outputs not listed for a state SHALL be 0, and alu_op SHALL be `FUNCT_ADD.
REQ-013 FETCH: mem_read=1, alu_src_a=0, alu_src_b=1, alu_op=ADD; while mem_ready=0, hold FETCH; when mem_ready=1, pulse ir_write=1 and pc_write=1 for that cycle, then go to DECODE.
REQ-014 DECODE: one cycle, no side effects, always go to EXEC; opcodes outside 0x0-0x5 (or 0x0-0x6 with REQ-027) SHALL raise illegal=1 for that cycle and go to FETCH instead.
REQ-015 EXEC, opcode 0x0 (R-type): alu_src_a=1, alu_src_b=0, alu_op=funct; next WB.
REQ-016 EXEC, opcode 0x1 (ADDI): alu_src_a=1, alu_src_b=2, alu_op=ADD; next WB.
REQ-017 EXEC, opcodes 0x2 (LW) and 0x3 (SW): address calculation as ADDI; next MEM.
REQ-018 EXEC, opcode 0x4 (BEQ): alu_src_a=1, alu_src_b=0, alu_op=SUB; pc_write=zero; next FETCH.
REQ-019 EXEC, opcode 0x5 (J): pc_write=1; next FETCH.
REQ-020 MEM: LW drives mem_read=1, SW drives mem_write=1; hold MEM while mem_ready=0; on mem_ready=1, LW goes to WB and SW goes to FETCH.
REQ-021 WB: reg_write=1 for exactly one cycle; mem_to_reg=1 for LW only; reg_dst=1 for R-type only; next FETCH.
REQ-022 Latency, zero wait states: R/ADDI 4 cycles, LW 5, SW 4, BEQ/J 3; each mem_ready=0 cycle adds one cycle.
REQ-023 ir_write and pc_write SHALL never be asserted together outside FETCH; mem_read and mem_write SHALL never be asserted together.

Reset
REQ-024 reset=1 at a rising edge SHALL force state to FETCH regardless of the current state, including mid-MEM wait.
REQ-025 While reset=1, all write strobes (pc_write, ir_write, mem_write, reg_write) and illegal SHALL be driven 0; mem_read=0.
REQ-026 The first cycle after reset deasserts SHALL be FETCH with mem_read=1.

Configuration
REQ-027 With macro MC_CONTROL_BNE_EN defined, opcode 0x6 (BNE) SHALL behave as BEQ with pc_write=~zero.
REQ-028 Without MC_CONTROL_BNE_EN, opcode 0x6 SHALL be illegal per REQ-014.

Verification
REQ-029 Reset mid-MEM of LW with mem_ready=0 -> next state FETCH, mem_write=0 and reg_write=0 throughout.
REQ-030 instr=0x0005 (R-type, funct=5), mem_ready=1 always -> states 0,1,2,4,0; alu_op=5 in EXEC; reg_write=1 and reg_dst=1 in WB only.
REQ-031 LW instr=0x2104, mem_ready=0 for 3 MEM cycles then 1 -> MEM held 4 cycles; WB with mem_to_reg=1; total 8 cycles.
REQ-032 BEQ instr=0x4000, zero=1 then repeat with zero=0 -> pc_write=1 in EXEC for zero=1 only, alu_op=`FUNCT_SUB in both.
REQ-033 instr=0x6000 -> illegal=1 in DECODE, then FETCH without MC_CONTROL_BNE_EN; with the macro defined and zero=0 -> pc_write=1 in EXEC.
REQ-034 instr=0xF000 -> illegal=1 for one cycle, no write strobe asserted after the FETCH cycle, returns to FETCH.
